// File: rtl/tx_arb_pkg.sv
// Shared encodings for the TX FIFO write-side arbiter.
package tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CTRL = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/tx_fifo_wr_arb.sv
// Frame-atomic round-robin arbiter for the TX FIFO write port (host DMA vs.
// MAC control frames); a frame starts only when the FIFO has MIN_FREE slots.
module tx_fifo_wr_arb
    import tx_arb_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 16,
    parameter int PTR      = 4,
    parameter int MIN_FREE = 4
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_data,
    input  logic               req0_last,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_data,
    input  logic               req1_last,
    output logic               req1_ready,
    output logic               fifo_wrreq,
    output logic [WIDTH-1:0]   fifo_data,
    input  logic               fifo_wrfull,
    input  logic [PTR:0]       fifo_wrusedw,
    output logic               busy,
    output logic               gnt,
    output logic [CNT_W-1:0]   frm_cnt0,
    output logic [CNT_W-1:0]   frm_cnt1
);

    localparam logic [PTR+1:0] DEPTH_L = (PTR+2)'(DEPTH);
    localparam logic [PTR+1:0] MIN_L   = (PTR+2)'(MIN_FREE);

    state_t           state, state_nxt;
    logic             gnt_nxt;
    logic [PTR+1:0]   free;
    logic             space_ok;
    logic             sel_valid, sel_last, xfer;
    logic [WIDTH-1:0] sel_data;

    assign free     = DEPTH_L - {1'b0, fifo_wrusedw};
    assign space_ok = (free >= MIN_L) && !fifo_wrfull;

    assign sel_valid = (gnt == REQ_CTRL) ? req1_valid : req0_valid;
    assign sel_last  = (gnt == REQ_CTRL) ? req1_last  : req0_last;
    assign sel_data  = (gnt == REQ_CTRL) ? req1_data  : req0_data;

    assign busy = (state == XFER);
    // Full FIFO stalls the granted requester without releasing the grant.
    assign xfer = busy && sel_valid && !fifo_wrfull;

    assign req0_ready = busy && (gnt == REQ_HOST) && !fifo_wrfull;
    assign req1_ready = busy && (gnt == REQ_CTRL) && !fifo_wrfull;
    assign fifo_wrreq = xfer;
    assign fifo_data  = xfer ? sel_data : '0;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
            gnt   <= REQ_CTRL;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        if (state == IDLE) begin
            // The requester that did not hold the last grant wins a tie.
            if ((req0_valid || req1_valid) && space_ok) begin
                state_nxt = XFER;
                if (req0_valid && req1_valid)
                    gnt_nxt = ~gnt;
                else
                    gnt_nxt = req1_valid ? REQ_CTRL : REQ_HOST;
            end
        end else begin
            if (xfer && sel_last)
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            frm_cnt0 <= '0;
            frm_cnt1 <= '0;
        end else if (xfer && sel_last) begin
            if (gnt == REQ_HOST)
                frm_cnt0 <= frm_cnt0 + CNT_W'(1);
            else
                frm_cnt1 <= frm_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// Directed bench for tx_fifo_wr_arb with hand-computed expectations.
module tb_tx_fifo_wr_arb;
    localparam int WIDTH = 64;
    localparam int PTR   = 4;

    logic             clk = 1'b0;
    logic             aclr;
    logic             req0_valid, req0_last, req0_ready;
    logic             req1_valid, req1_last, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data, fifo_data;
    logic             fifo_wrreq, fifo_wrfull, busy, gnt;
    logic [PTR:0]     fifo_wrusedw;
    logic [15:0]      frm_cnt0, frm_cnt1;

    int n_chk = 0;
    int n_err = 0;

    tx_fifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(16), .PTR(PTR), .MIN_FREE(4)) dut (
        .clk(clk), .aclr(aclr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_wrfull(fifo_wrfull),
        .fifo_wrusedw(fifo_wrusedw), .busy(busy), .gnt(gnt),
        .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        req0_valid = 0; req0_last = 0; req0_data = '0;
        req1_valid = 0; req1_last = 0; req1_data = '0;
        fifo_wrfull = 0; fifo_wrusedw = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        aclr = 1;
        #1;
        aclr = 0;
        #1;
    endtask

    logic        exp_busy [13] = '{0,1,1,0,1,1,0,1,1,0,1,1,0};
    logic [11:0] exp_dat  [13] = '{0,'h100,'h101,0,'h200,'h201,0,'h102,'h103,0,'h202,'h203,0};
    logic        exp_gnt  [13] = '{0,0,0,0,1,1,0,0,0,0,1,1,0};

    initial begin
        int i0, i1;
        clr_inputs();
        aclr = 1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 1);
        chk("rst_cnt0", frm_cnt0, 0);
        chk("rst_cnt1", frm_cnt1, 0);
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk("rst_wrreq", fifo_wrreq, 0);
        chk("rst_data", fifo_data, 0);
        aclr = 0;
        tick();

        // 3-word host frame into an empty FIFO
        req0_valid = 1; req0_data = 'hA1; req0_last = 0;
        #1;
        chk("t1_idle_rdy", req0_ready, 0);
        chk("t1_idle_wr", fifo_wrreq, 0);
        tick();
        chk("t1_gnt", gnt, 0);
        chk("t1_busy", busy, 1);
        chk("t1_w0", {fifo_wrreq, fifo_data[7:0]}, 'h1A1);
        tick();
        req0_data = 'hA2;
        #1;
        chk("t1_w1", {fifo_wrreq, fifo_data[7:0]}, 'h1A2);
        tick();
        req0_data = 'hA3; req0_last = 1;
        #1;
        chk("t1_w2", {fifo_wrreq, fifo_data[7:0]}, 'h1A3);
        chk("t1_r1rdy", req1_ready, 0);
        tick();
        req0_valid = 0; req0_last = 0;
        #1;
        chk("t1_done_busy", busy, 0);
        chk("t1_cnt0", frm_cnt0, 1);
        chk("t1_idle_data", {fifo_wrreq, fifo_data}, 0);

        // Both requesters stream 2-word frames from reset
        do_reset();
        i0 = 0; i1 = 0;
        for (int c = 0; c < 13; c++) begin
            req0_valid = (c < 12); req0_data = 64'(32'h100 + i0); req0_last = i0[0];
            req1_valid = (c < 12); req1_data = 64'(32'h200 + i1); req1_last = i1[0];
            #1;
            chk($sformatf("rr_busy%0d", c), busy, exp_busy[c]);
            chk($sformatf("rr_wr%0d", c), fifo_wrreq, exp_busy[c]);
            chk($sformatf("rr_data%0d", c), fifo_data, 64'(exp_dat[c]));
            if (exp_busy[c]) chk($sformatf("rr_gnt%0d", c), gnt, exp_gnt[c]);
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
            tick();
        end
        chk("rr_cnt0", frm_cnt0, 2);
        chk("rr_cnt1", frm_cnt1, 2);

        // MIN_FREE threshold at frame start
        do_reset();
        fifo_wrusedw = 13; req0_valid = 1; req0_last = 1; req0_data = 'h55;
        #1;
        tick();
        chk("mf_nogrant", busy, 0);
        chk("mf_nowr", fifo_wrreq, 0);
        fifo_wrusedw = 12;
        tick();
        chk("mf_grant", busy, 1);
        chk("mf_gnt", gnt, 0);
        chk("mf_wr", {fifo_wrreq, fifo_data[7:0]}, 'h155);
        tick();
        req0_valid = 0;
        #1;
        chk("mf_cnt0", frm_cnt0, 1);

        // wrfull stall on word 2 of a 4-word frame
        do_reset();
        req0_valid = 1; req0_data = 'hB0;
        tick();
        chk("st_w0", {fifo_wrreq, fifo_data[7:0]}, 'h1B0);
        tick();
        req0_data = 'hB1; fifo_wrfull = 1;
        for (int s = 0; s < 2; s++) begin
            #1;
            chk($sformatf("st_rdy%0d", s), req0_ready, 0);
            chk($sformatf("st_wr%0d", s), {fifo_wrreq, fifo_data}, 0);
            chk($sformatf("st_hold%0d", s), {busy, gnt}, 2'b10);
            tick();
        end
        fifo_wrfull = 0;
        #1;
        chk("st_w1", {fifo_wrreq, fifo_data[7:0]}, 'h1B1);
        tick();
        req0_data = 'hB2;
        #1;
        chk("st_w2", {fifo_wrreq, fifo_data[7:0]}, 'h1B2);
        tick();
        req0_data = 'hB3; req0_last = 1;
        #1;
        chk("st_w3", {fifo_wrreq, fifo_data[7:0]}, 'h1B3);
        tick();
        req0_valid = 0; req0_last = 0;
        #1;
        chk("st_end", {busy, frm_cnt0[3:0]}, 5'h01);

        // req1 valid gap mid-frame while req0 waits
        do_reset();
        req1_valid = 1; req1_data = 'hC0;
        tick();
        req0_valid = 1; req0_data = 'hD0;
        #1;
        chk("gap_gnt", gnt, 1);
        chk("gap_w0", {fifo_wrreq, fifo_data[7:0]}, 'h1C0);
        tick();
        req1_valid = 0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("gap_hold%0d", s), {busy, gnt}, 2'b11);
            chk($sformatf("gap_r0rdy%0d", s), req0_ready, 0);
            chk($sformatf("gap_wr%0d", s), fifo_wrreq, 0);
            tick();
        end
        req1_valid = 1; req1_data = 'hC1; req1_last = 1;
        #1;
        chk("gap_w1", {fifo_wrreq, fifo_data[7:0]}, 'h1C1);
        chk("gap_rdy", {req0_ready, req1_ready}, 2'b01);
        tick();
        req1_valid = 0; req1_last = 0;
        #1;
        chk("gap_cnt1", frm_cnt1, 1);

        // aclr mid-frame: req0 has been waiting, so it is granted now
        tick();
        chk("ab_gnt", {busy, gnt}, 2'b10);
        tick();
        #1;
        aclr = 1;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_gnt_rst", gnt, 1);
        chk("ab_cnt", {frm_cnt0, frm_cnt1}, 0);
        chk("ab_wr", {fifo_wrreq, req0_ready}, 0);
        aclr = 0;
        req0_data = 'hE0; req0_last = 1;
        tick();
        chk("ab_regrant", {busy, gnt, fifo_wrreq}, 3'b101);
        chk("ab_data", fifo_data, 'hE0);
        tick();
        req0_valid = 0;
        #1;
        chk("ab_cnt0", frm_cnt0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tx_fifo_wr_arb.md
Name: tx_fifo_wr_arb

Overview:
- Frame-atomic round-robin arbiter that shares the write side of the TX data FIFO between two requesters: requester 0 is the host/DMA frame path, requester 1 is the MAC control (pause) frame generator.
- Grants one whole frame at a time, drives the FIFO write port directly, and starts a new frame only when the FIFO has enough free slots.
- Sits in the wrclk domain, in front of the TX FIFO instance.

Parameters:
- WIDTH, 64, data word width; matches the FIFO WIDTH.
- DEPTH, 16, FIFO depth in words.
- PTR, 4, log2(DEPTH); wrusedw is PTR+1 bits.
- MIN_FREE, 4, minimum free FIFO slots required to grant a new frame (1..DEPTH).

Ports:
- clk  in  1  write-side clock (FIFO wrclk)
- aclr  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 word valid
- req0_data  in  WIDTH  requester 0 word
- req0_last  in  1  requester 0 last word of frame
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 word valid
- req1_data  in  WIDTH  requester 1 word
- req1_last  in  1  requester 1 last word of frame
- req1_ready  out  1  requester 1 word accepted this cycle
- fifo_wrreq  out  1  FIFO write request
- fifo_data  out  WIDTH  FIFO write data
- fifo_wrfull  in  1  FIFO full
- fifo_wrusedw  in  PTR+1  FIFO words in use
- busy  out  1  a frame is in progress
- gnt  out  1  index of the current or last granted requester
- frm_cnt0  out  16  frames completed by requester 0, wraps
- frm_cnt1  out  16  frames completed by requester 1, wraps

Behaviour:
- Reset: aclr asserts asynchronously. Required values while and after reset:
  - state = IDLE, busy = 0, gnt = 1 so that requester 0 wins first.
  - frm_cnt0 = frm_cnt1 = 0; all readys = 0; fifo_wrreq = 0.
- free = DEPTH - fifo_wrusedw, computed in PTR+2 bits, unsigned. space_ok = (free >= MIN_FREE) & ~fifo_wrfull.
- IDLE:
  - If any reqN_valid and space_ok, register a grant and go to XFER on the next edge.
  - Round robin: the requester that is not gnt has priority. If only one requester is valid, it wins.
  - Arbitration costs exactly one cycle: no word is accepted in IDLE.
- XFER, with g = gnt:
  - reqg_ready = ~fifo_wrfull, combinational. The other requester's ready is 0.
  - fifo_wrreq = reqg_valid & reqg_ready. fifo_data = reqg_data (mux, zero latency).
  - A word transfers when valid & ready are both high.
  - A transfer with last = 1 increments frm_cntg and returns to IDLE the next cycle. Back-to-back frames therefore have a 1-cycle bubble.
  - A valid gap mid-frame holds XFER. The grant never changes mid-frame.
- busy = (state == XFER).
- fifo_wrfull mid-frame stalls the transfer (ready = 0) and does not drop the grant. MIN_FREE governs frame start only.
- The request that is not granted is held off regardless of its last or valid state.
- Counters wrap from 0xFFFF to 0x0000.
- aclr mid-frame aborts: the FIFO holds a partial frame. The FIFO is cleared by the same aclr at system level.
- fifo_data = 0 when fifo_wrreq = 0. This is a deterministic idle value.

Decomposition:
- tx_arb_pkg holds:
  - the state encoding (IDLE = 1'b0, XFER = 1'b1);
  - the requester index constants (REQ_HOST = 0, REQ_CTRL = 1);
  - the counter width constant CNT_W = 16.
- No sub-module: the round-robin select, the mux and the counters stay inline.

Test Plan:
- Reset, then req0_valid with a 3-word frame (last on word 3) and an empty FIFO:
  - gnt = 0 and busy = 1 one cycle after valid;
  - fifo_wrreq is high for 3 cycles;
  - frm_cnt0 = 1; IDLE the cycle after the last word.
- Both requesters hold 2-word frames continuously, from reset:
  - grant order is 0, 1, 0, 1;
  - each frame is followed by exactly 1 idle cycle;
  - after 4 frames, frm_cnt0 = 2 and frm_cnt1 = 2.
- fifo_wrusedw = 13 with DEPTH = 16 and MIN_FREE = 4, req0 valid: no grant. Drop wrusedw to 12: grant on the next cycle.
- fifo_wrfull = 1 for 2 cycles during word 2 of a 4-word frame:
  - req0_ready = 0 and fifo_wrreq = 0 during the stall;
  - the grant is held; all 4 words are written in order.
- req1 drops valid for 3 cycles mid-frame while req0 is valid:
  - busy stays 1 and gnt stays 1;
  - req0_ready = 0 throughout.
- aclr pulsed mid-frame:
  - busy = 0, counters = 0 and gnt = 1 immediately, without a clock edge;
  - after release, a new req0 frame is granted normally.
